param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO replacing the fixed 8x1024 byte FIFO in the RSA/RFID datapath.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_sdp_ram.sv | 52 +++++
 rtl/param_sync_fifo.sv | 122 ++++++++++++
 tb/tb_param_sync_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family.
//   fifo_clog2     : ceil(log2(value)), used to size pointers from DEPTH
//   RSA_WIDTH/DEPTH: default geometry of the RSA/RFID byte path
package fifo_pkg;

  localparam int RSA_WIDTH = 8;
  localparam int RSA_DEPTH = 1024;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one read port.
// REG_READ=1 gives a registered read (block-RAM style, output cleared by i_clr);
// REG_READ=0 gives an asynchronous read of i_rd_addr.
// Ports:
//   clk       clock
//   i_clr     synchronous clear of the read output register
//   i_wr_en   write strobe
//   i_wr_addr write address
//   i_wr_data write data
//   i_rd_en   read strobe (registered mode only)
//   i_rd_addr read address
//   o_rd_data read data
module fifo_sdp_ram #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter bit REG_READ = 1'b1,
  localparam int AW      = fifo_pkg::fifo_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is never reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk) begin
        if (i_clr)        r_q <= '0;
        else if (i_rd_en) r_q <= r_mem[i_rd_addr];
      end
      assign o_rd_data = r_q;
    end else begin : g_async_read
      // Strobes have no function with an asynchronous read port.
      logic w_unused_ok;
      assign w_unused_ok = &{1'b0, i_clr, i_rd_en};
      assign o_rd_data   = r_mem[i_rd_addr];
    end
  endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO between the UART/RFID byte source and the RSA core.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear of pointers/count/flags (memory kept)
//   wr_en, data_in  write request and data
//   rd_en           read request
//   data_out        read data (registered, or head word when FWFT=1)
//   data_valid      FWFT=0: one-cycle pulse with data_out; FWFT=1: !empty
//   full, empty, almost_full, almost_empty  occupancy flags
//   count           occupancy 0..DEPTH
//   overflow, underflow  sticky error bits
//   head_o, tail_o  write/read pointers (debug)
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = RSA_WIDTH,
  parameter int DEPTH    = RSA_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter bit FWFT     = 1'b0,
  localparam int AW      = fifo_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    head_o,
  output logic [AW-1:0]    tail_o
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic w_clr;
  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_clr   = rst | flush;
  // count has one more bit than the pointers so DEPTH itself is representable.
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance is judged on the pre-edge occupancy; clear dominates both.
  assign w_wr_acc = wr_en & ~w_full  & ~w_clr;
  assign w_rd_acc = rd_en & ~w_empty & ~w_clr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_head <= r_head + 1'b1;
      if (w_rd_acc) r_tail <= r_tail + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en & w_full)  r_overflow  <= 1'b1;
      if (rd_en & w_empty) r_underflow <= 1'b1;
    end
  end

  fifo_sdp_ram #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .REG_READ (!FWFT)
  ) u_ram (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_head),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_tail),
    .o_rd_data (data_out)
  );

  generate
    if (FWFT) begin : g_fwft
      assign data_valid = ~w_empty;
    end else begin : g_std
      // Pulse aligned with the registered RAM output; reset drops in-flight reads.
      logic r_data_valid;
      always_ff @(posedge clk) begin
        if (w_clr) r_data_valid <= 1'b0;
        else       r_data_valid <= w_rd_acc;
      end
      assign data_valid = r_data_valid;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= (AW+1)'(AF_LEVEL));
  assign almost_empty = (r_count <= (AW+1)'(AE_LEVEL));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign head_o       = r_head;
  assign tail_o       = r_tail;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int W     = 8;
  localparam int D     = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         rd_en = 1'b0;

  // FWFT=0 instance outputs
  logic [W-1:0]  dout0;
  logic          dv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [AW:0]   cnt0;
  logic [AW-1:0] head0, tail0;
  // FWFT=1 instance outputs
  logic [W-1:0]  dout1;
  logic          dv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0]   cnt1;
  logic [AW-1:0] head1, tail1;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .data_valid(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
    .underflow(unf0), .head_o(head0), .tail_o(tail0)
  );

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .data_valid(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
    .underflow(unf1), .head_o(head1), .tail_o(tail1)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  bit           m_ovf, m_unf, m_dv;
  logic [W-1:0] m_dout;
  int           m_head, m_tail;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Applies the FIFO rules to the model using the state before the edge.
  task automatic model_update(input bit rs, input bit fl, input bit w,
                              input logic [W-1:0] d, input bit r);
    bit is_full, is_empty, wa, ra;
    if (rs || fl) begin
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0;
      m_head = 0; m_tail = 0;
    end else begin
      is_full  = (exp_q.size() == D);
      is_empty = (exp_q.size() == 0);
      wa = w && !is_full;
      ra = r && !is_empty;
      if (w && is_full)  m_ovf = 1;
      if (r && is_empty) m_unf = 1;
      if (ra) begin
        m_dout = exp_q.pop_front();
        m_dv   = 1;
        m_tail = (m_tail + 1) % D;
      end else begin
        m_dv = 0;
      end
      if (wa) begin
        exp_q.push_back(d);
        m_head = (m_head + 1) % D;
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("full0",  32'(full0),  32'(n == D));
    chk("full1",  32'(full1),  32'(n == D));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("af0",    32'(af0),    32'(n >= AF));
    chk("af1",    32'(af1),    32'(n >= AF));
    chk("ae0",    32'(ae0),    32'(n <= AE));
    chk("ae1",    32'(ae1),    32'(n <= AE));
    chk("ovf0",   32'(ovf0),   32'(m_ovf));
    chk("ovf1",   32'(ovf1),   32'(m_ovf));
    chk("unf0",   32'(unf0),   32'(m_unf));
    chk("unf1",   32'(unf1),   32'(m_unf));
    chk("head0",  32'(head0),  32'(m_head));
    chk("head1",  32'(head1),  32'(m_head));
    chk("tail0",  32'(tail0),  32'(m_tail));
    chk("tail1",  32'(tail1),  32'(m_tail));
    chk("dv0",    32'(dv0),    32'(m_dv));
    chk("dout0",  32'(dout0),  32'(m_dout));
    chk("dv1",    32'(dv1),    32'(n != 0));
    if (n != 0) chk("dout1", 32'(dout1), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_step(input bit rs, input bit fl, input bit w,
                         input logic [W-1:0] d, input bit r);
    rst = rs; flush = fl; wr_en = w; data_in = d; rd_en = r;
    model_update(rs, fl, w, d, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();  do_step(1, 0, 0, '0, 0); endtask
  task automatic do_wr(input logic [W-1:0] d); do_step(0, 0, 1, d, 0); endtask
  task automatic do_rd();     do_step(0, 0, 0, '0, 1); endtask
  task automatic do_idle();   do_step(0, 0, 0, '0, 0); endtask
  task automatic do_wr_rd(input logic [W-1:0] d); do_step(0, 0, 1, d, 1); endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    @(negedge clk);

    phase = "reset";
    do_reset();
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_ae",    32'(ae1),    32'd1);

    phase = "fill_drain";
    for (int i = 1; i <= 16; i++) do_wr(W'(i));
    chk("full_at16", 32'(full0), 32'd1);
    do_wr(8'h11);
    chk("ovf_17th", 32'(ovf0), 32'd1);
    for (int i = 0; i < 16; i++) do_rd();
    do_idle();
    chk("last_word", 32'(dout0), 32'h10);

    phase = "wrap";
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) do_wr(W'($urandom_range(0, 255)));
      for (int i = 0; i < 10; i++) do_rd();
    end
    chk("head_wrap", 32'(head0), 32'd4);
    chk("tail_wrap", 32'(tail1), 32'd4);

    phase = "simul";
    do_reset();
    for (int i = 0; i < 5; i++) do_wr(W'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) do_wr_rd(W'($urandom_range(0, 255)));
    chk("cnt_steady", 32'(cnt0), 32'd5);
    for (int i = 0; i < 11; i++) do_wr(W'($urandom_range(0, 255)));
    do_wr_rd(8'h3C);
    chk("full_wr_rd", 32'(cnt1), 32'd15);
    for (int i = 0; i < 15; i++) do_rd();
    do_wr_rd(8'h5A);
    chk("empty_wr_rd", 32'(cnt0), 32'd1);
    chk("empty_unf",   32'(unf1), 32'd1);
    do_rd();

    phase = "fwft";
    do_reset();
    do_wr(8'hA5);
    chk("fwft_head", 32'(dout1), 32'hA5);
    chk("std_no_dv", 32'(dv0), 32'd0);
    do_rd();
    chk("std_data", 32'(dout0), 32'hA5);
    do_idle();

    phase = "flush";
    do_reset();
    for (int i = 0; i < 16; i++) do_wr(W'($urandom_range(0, 255)));
    do_wr(8'hEE);
    for (int i = 0; i < 7; i++) do_rd();
    chk("pre_flush_cnt", 32'(cnt0), 32'd9);
    do_step(0, 1, 1, 8'h77, 0);
    chk("flush_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 3; i++) do_wr(W'($urandom_range(0, 255)));
    do_rd();
    do_step(1, 0, 0, '0, 1);
    chk("rst_mid_dv",   32'(dv0),   32'd0);
    chk("rst_mid_tail", 32'(tail0), 32'd0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      do_step(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
